// File: rtl/count_seq_if.sv
// Handshake bundle between the top-level control FSM, the CA1 counter and count_seq_ctrl.
// The controller uses the slave modport; the environment driving it uses master.
interface count_seq_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] limit;
   logic             step_ok;
   logic [WIDTH-1:0] cnt;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             busy;
   logic             last;
   logic             done;
   logic             err;

   modport master (
      output start, limit, step_ok, cnt,
      input  cnt_clr, cnt_inc, busy, last, done, err
   );

   modport slave (
      input  start, limit, step_ok, cnt,
      output cnt_clr, cnt_inc, busy, last, done, err
   );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencing controller for the CA1 4-bit up counter: clear, step to a captured limit, pulse done.
// Define COUNT_SEQ_TIMEOUT_EN to add the stall counter and the ERR abort path.
module count_seq_ctrl #(
   parameter int WIDTH          = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input logic        clk,
   input logic        reset,
   count_seq_if.slave bus
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("count_seq_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef COUNT_SEQ_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, CLR, RUN, DONE, ERR} state_t;
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
   logic [SW-1:0] stall;
   logic          err_q;
`else
   typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] limit_q;
   logic             clr_q;
   logic             busy_q;
   logic             done_q;
   logic             at_limit;

   assign at_limit = (bus.cnt == limit_q);

   // Moore flags are registered alongside the state so they come straight off flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         limit_q <= '0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef COUNT_SEQ_TIMEOUT_EN
         stall   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         clr_q  <= 1'b0;
         done_q <= 1'b0;
`ifdef COUNT_SEQ_TIMEOUT_EN
         err_q  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.start) begin
                  limit_q <= bus.limit;
                  state   <= CLR;
                  clr_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            CLR: begin
               state <= RUN;
`ifdef COUNT_SEQ_TIMEOUT_EN
               stall <= '0;
`endif
            end
            RUN: begin
               if (bus.step_ok && at_limit) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
`ifdef COUNT_SEQ_TIMEOUT_EN
               end else if (bus.step_ok) begin
                  stall <= '0;
               end else if (stall == SW'(TIMEOUT_CYCLES)) begin
                  state  <= ERR;
                  err_q  <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  stall <= stall + SW'(1);
`endif
               end
            end
            DONE: state <= IDLE;
`ifdef COUNT_SEQ_TIMEOUT_EN
            ERR:  state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
      end
   end

   // Increment is withheld at the limit so the counter can never wrap.
   assign bus.cnt_inc = (state == RUN) && bus.step_ok && !at_limit;
   assign bus.last    = (state == RUN) && at_limit;
   assign bus.cnt_clr = clr_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
`ifdef COUNT_SEQ_TIMEOUT_EN
   assign bus.err     = err_q;
`else
   assign bus.err     = 1'b0;
`endif

endmodule
